// File: rtl/port_debounce.sv
// Joystick/console-switch input conditioner for the RIOT ports.
// Two-flop synchronizer, shared sample prescaler, per-bit debounce counters.
module port_debounce #(
    parameter int TICK_DIV   = 1024,
    parameter int STABLE_CNT = 4
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       BYPASS,
    input  logic [7:0] JOY_RAW,
    input  logic [7:0] SW_RAW,
    output logic [7:0] PA_IN,
    output logic [7:0] PB_IN,
    output logic       CHANGE,
    output logic       TICK
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CPRE  = CW'(STABLE_CNT - 1);

    logic [15:0]         sync1_q;
    logic [15:0]         sync2_q;
    logic [PW-1:0]       pre_q;
    logic [PW-1:0]       pre_d;
    logic                tick_q;
    logic [15:0][CW-1:0] cnt_q;
    logic [15:0][CW-1:0] cnt_d;
    logic [15:0]         out_q;
    logic [15:0]         out_d;
    logic                chg_q;

    // Tick is registered so it is high exactly while the count sits at TICK_DIV-1
    always_comb begin
        pre_d = (pre_q == PLAST) ? '0 : pre_q + PW'(1);
    end

    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 16; i++) begin
            if (BYPASS) begin
                out_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else if (tick_q) begin
                if (sync2_q[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CPRE) begin
                    out_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            sync1_q <= '1;
            sync2_q <= '1;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '1;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= {SW_RAW, JOY_RAW};
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            tick_q  <= (pre_d == PLAST);
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            chg_q   <= (out_d != out_q);
        end
    end

    assign PA_IN  = out_q[7:0];
    assign PB_IN  = out_q[15:8];
    assign CHANGE = chg_q;
    assign TICK   = tick_q;

endmodule

// File: tb/tb_port_debounce.sv
// Bench for port_debounce: vector table plus change scoreboard,
// with hand sequences for glitch, bypass, reset and fast configuration.
module tb_port_debounce;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       byp = 1'b0;
    logic [7:0] joy = 8'hFF;
    logic [7:0] sw  = 8'hFF;
    logic [7:0] pa, pb;
    logic       chg, tick;

    logic       byp_b = 1'b0;
    logic [7:0] joy_b = 8'hFF;
    logic [7:0] sw_b  = 8'hFF;
    logic [7:0] pa_b, pb_b;
    logic       chg_b, tick_b;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;
    logic [15:0] prev;

    typedef struct {
        logic [7:0] pa;
        logic [7:0] pb;
        int         t0;
        int         lmin;
        int         lmax;
    } exp_t;

    typedef struct {
        logic [7:0] joy;
        logic [7:0] sw;
        logic [7:0] pa;
        logic [7:0] pb;
        int         lmin;
        int         lmax;
    } vec_t;

    exp_t q[$];
    exp_t me;
    int   lat;

    port_debounce #(.TICK_DIV(4), .STABLE_CNT(3)) dut (
        .CLK(clk), .RES(res), .BYPASS(byp),
        .JOY_RAW(joy), .SW_RAW(sw),
        .PA_IN(pa), .PB_IN(pb), .CHANGE(chg), .TICK(tick)
    );

    port_debounce #(.TICK_DIV(1), .STABLE_CNT(1)) dut_b (
        .CLK(clk), .RES(res), .BYPASS(byp_b),
        .JOY_RAW(joy_b), .SW_RAW(sw_b),
        .PA_IN(pa_b), .PB_IN(pb_b), .CHANGE(chg_b), .TICK(tick_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(string nm, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", nm, got, exp);
        end
    endtask

    // Scoreboard: every CHANGE pulse pops one expected output pair
    initial forever begin
        @(negedge clk);
        if (!mon_en) begin
            prev = {pa, pb};
        end else begin
            if (chg || {pa, pb} != prev) begin
                checks++;
                if (!(chg && {pa, pb} != prev)) begin
                    errors++;
                    $display("FAIL chg_pulse: chg=%b got %h prev %h", chg, {pa, pb}, prev);
                end
            end
            if (chg) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got %h exp none", {pa, pb});
                end else begin
                    me = q.pop_front();
                    lat = edge_n - me.t0;
                    check("chg_value", {pa, pb}, {me.pa, me.pb});
                    checks++;
                    if (lat < me.lmin || lat > me.lmax) begin
                        errors++;
                        $display("FAIL latency: got %0d exp %0d..%0d", lat, me.lmin, me.lmax);
                    end
                end
            end
            prev = {pa, pb};
        end
    end

    task automatic drain(int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending exp 0", q.size());
            q.delete();
        end
    endtask

    task automatic apply(vec_t v);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1;
        joy = v.joy;
        sw  = v.sw;
        q.push_back('{v.pa, v.pb, edge_n, v.lmin, v.lmax});
        drain(40);
        repeat (6) @(posedge clk);
    endtask

    // Returns just after the edge that consumes a sample tick
    task automatic align();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 8);
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL align: got tick %b exp 1", tick);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vt[5];
    vec_t vr;
    logic [7:0] bv[4];
    logic [7:0] old;

    initial begin
        vt[0] = '{8'hEF, 8'hFF, 8'hEF, 8'hFF, 11, 15};
        vt[1] = '{8'h0F, 8'hF4, 8'h0F, 8'hF4, 11, 15};
        vt[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 11, 15};
        vt[3] = '{8'h5A, 8'hA5, 8'h5A, 8'hA5, 11, 15};
        vt[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 11, 15};
        bv[0] = 8'h00;
        bv[1] = 8'h55;
        bv[2] = 8'hFE;
        bv[3] = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pa", pa, 8'hFF);
        check("rst_pb", pb, 8'hFF);
        check("rst_chg", chg, 1'b0);
        check("rst_tick", tick, 1'b0);

        @(negedge clk);
        res = 1'b0;
        prev = 16'hFFFF;
        mon_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("tick_phase", tick, (i % 4 == 3));
        end
        check("idle_pa", pa, 8'hFF);
        check("idle_pb", pb, 8'hFF);

        for (int i = 0; i < 5; i++) apply(vt[i]);

        // Glitch back high for one tick restarts the count
        align();
        joy = 8'hFE;
        repeat (8) @(posedge clk);
        #1;
        joy = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        joy = 8'hFE;
        q.push_back('{8'hFE, 8'hFF, edge_n, 12, 12});
        drain(40);
        repeat (6) @(posedge clk);
        vr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 11, 15};
        apply(vr);

        @(posedge clk);
        #1;
        byp = 1'b1;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            sw[3] = ~sw[3];
            q.push_back('{8'hFF, sw, edge_n, 3, 3});
        end
        drain(20);
        @(posedge clk);
        #1;
        byp = 1'b0;
        repeat (4) @(posedge clk);
        vr = '{8'hFF, 8'hF7, 8'hFF, 8'hF7, 11, 15};
        apply(vr);

        // Reset mid-way through a 2-of-3 pending transition
        align();
        joy = 8'h7F;
        repeat (9) @(posedge clk);
        #2;
        mon_en = 1'b0;
        res = 1'b1;
        #1;
        check("res_pa", pa, 8'hFF);
        check("res_pb", pb, 8'hFF);
        check("res_chg", chg, 1'b0);
        check("res_tick", tick, 1'b0);
        #1;
        res = 1'b0;
        q.push_back('{8'h7F, 8'hF7, edge_n, 12, 12});
        prev = {pa, pb};
        mon_en = 1'b1;
        drain(40);
        repeat (6) @(posedge clk);

        for (int i = 0; i < 4; i++) begin
            old = (i == 0) ? 8'hFF : bv[i-1];
            @(posedge clk);
            #1;
            joy_b = bv[i];
            repeat (3) begin
                @(negedge clk);
                check("fast_hold", pa_b, old);
            end
            @(negedge clk);
            check("fast_new", pa_b, bv[i]);
            check("fast_chg", chg_b, 1'b1);
            @(negedge clk);
            check("fast_chg_end", chg_b, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

endmodule

// File: doc/port_debounce.md
PORT_DEBOUNCE -- requirements
Module: port_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1024: CLK cycles per debounce sample tick (>=1).
REQ-002 SHALL have parameter STABLE_CNT, default 4: consecutive differing samples needed to accept a new level (>=1).
REQ-003 SHALL have port CLK  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port RES  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port BYPASS  input  1  1 = skip debounce; outputs follow the synchronized inputs.
REQ-006 SHALL have port JOY_RAW  input  8  raw asynchronous joystick pins, active-low, idle high.
REQ-007 SHALL have port SW_RAW  input  8  raw asynchronous console switches, active-low, idle high.
REQ-008 SHALL have port PA_IN  output  8  debounced JOY_RAW; drives RIOT port A input.
REQ-009 SHALL have port PB_IN  output  8  debounced SW_RAW; drives RIOT port B input.
REQ-010 SHALL have port CHANGE  output  1  one-cycle pulse when any PA_IN/PB_IN bit changes.
REQ-011 SHALL have port TICK  output  1  one-cycle sample-tick strobe, for observation.

Function
REQ-012 SHALL pass each of the 16 raw bits through a 2-flop synchronizer before any other use.
REQ-013 SHALL run a prescaler counting 0..TICK_DIV-1 and wrapping to 0; TICK=1 in the cycle the count equals TICK_DIV-1.
REQ-014 SHALL assert TICK every cycle when TICK_DIV=1.
REQ-015 SHALL give each bit an independent saturating counter, width clog2(STABLE_CNT+1); no bit affects another.
REQ-016 SHALL, on TICK with the synchronized bit equal to its output bit, clear that bit's counter to 0.
REQ-017 SHALL, on TICK with the bits differing, increment the counter; when the incremented value equals STABLE_CNT, load the output with the synchronized bit and clear the counter, in the same edge.
REQ-018 SHALL hold counters and outputs unchanged in cycles without TICK (BYPASS=0).
REQ-019 SHALL treat any single agreeing sample (glitch back) as a full restart of that bit's count.
REQ-020 SHALL, with BYPASS=1, load outputs from the synchronized bits every cycle, hold all counters at 0, and keep the prescaler running.
REQ-021 SHALL, on BYPASS deasserting, resume debouncing from counters = 0 against the current outputs.
REQ-022 SHALL register PA_IN, PB_IN and CHANGE; there SHALL be no combinational path from inputs to outputs.
REQ-023 SHALL drive CHANGE=1 in exactly the first cycle that a new PA_IN/PB_IN value is visible, and 0 otherwise; simultaneous changes of several bits SHALL give one pulse.
REQ-024 SHALL, with BYPASS=0, update an output bit no sooner than 2+TICK_DIV*(STABLE_CNT-1)+1 and no later than 2+TICK_DIV*STABLE_CNT+1 cycles after a raw bit settles at a new level.

Reset
REQ-025 SHALL, while RES=1, asynchronously force synchronizer flops to 1, PA_IN=8'hFF, PB_IN=8'hFF, all counters=0, prescaler=0, CHANGE=0, TICK=0.
REQ-026 SHALL, on RES asserting mid-count, abandon all pending transitions with no CHANGE pulse.
REQ-027 SHALL start its first prescaler period at count 0 on the first edge after RES deasserts.

Verification (TICK_DIV=4, STABLE_CNT=3 unless stated)
REQ-028 SHALL cover: reset then all raw inputs 1 -> PA_IN=PB_IN=8'hFF, CHANGE never pulses, TICK every 4th cycle.
REQ-029 SHALL cover: JOY_RAW[4] 1->0 held -> PA_IN=8'hEF within 11..15 cycles, exactly one CHANGE pulse in the same cycle, PB_IN unchanged.
REQ-030 SHALL cover: JOY_RAW[0] low for 2 ticks, high for 1 tick, then low -> no change until 3 further consecutive low ticks, then PA_IN=8'hFE.
REQ-031 SHALL cover: SW_RAW=8'hF4 and JOY_RAW=8'h0F applied in the same cycle -> both outputs update on the same edge with a single CHANGE pulse.
REQ-032 SHALL cover: BYPASS=1, SW_RAW[3] toggled each cycle -> PB_IN[3] follows with 3-cycle latency and CHANGE pulses every cycle; BYPASS=0 then resumes the 3-tick rule.
REQ-033 SHALL cover: RES pulse asserted during a pending 2-of-3 transition, between clock edges -> outputs 8'hFF immediately, with no CHANGE; TICK_DIV=1, STABLE_CNT=1 -> PA_IN follows JOY_RAW with 3-cycle latency.
